// File: rtl/rle_decompressor.sv
// Run-length decompressor for one io_fsm byte lane: expands a length-prefixed
// stream of run/literal headers into addressed element writes and an eob pulse.
module rle_decompressor #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              eob,
  output logic              busy,
  output logic              err
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  typedef enum logic [2:0] {IDLE, LEN, HDR, RUN_VAL, RUN_EMIT, LIT, DONE} state_t;

  state_t            state;
  logic [DATA_W-1:0] remaining;
  logic [DATA_W-1:0] cnt;
  logic [DATA_W-1:0] run_val;
  logic [ADDR_W-1:0] index;

  logic              xfer;
  logic              emit;
  logic              last;
  logic [DATA_W-1:0] emit_data;
  logic [DATA_W-1:0] hdr_len;
  state_t            exit_state;

  assign in_ready   = (state == LEN) || (state == HDR) || (state == RUN_VAL) || (state == LIT);
  assign xfer       = in_valid & in_ready;
  assign emit       = (state == RUN_EMIT) || (xfer && ((state == RUN_VAL) || (state == LIT)));
  assign emit_data  = (state == RUN_EMIT) ? run_val : in_data;
  assign last       = (cnt == DATA_W'(1));
  assign hdr_len    = {1'b0, in_data[DATA_W-2:0]} + DATA_W'(1);
  assign exit_state = (remaining == DATA_W'(1)) ? DONE : HDR;
  // eob can fire while already back in IDLE, and the object is still in flight then
  assign busy       = (state != IDLE) || eob;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      remaining <= '0;
      cnt       <= '0;
      run_val   <= '0;
      index     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_addr  <= BASE;
      eob       <= 1'b0;
      err       <= 1'b0;
    end else begin
      out_valid <= emit;
      eob       <= 1'b0;
      if (emit) begin
        out_data  <= emit_data;
        out_addr  <= BASE + index;
        index     <= index + 1'b1;
        remaining <= remaining - 1'b1;
        cnt       <= cnt - 1'b1;
      end
      case (state)
        IDLE: begin
          if (start && !eob) begin
            state     <= LEN;
            remaining <= '0;
            index     <= '0;
            err       <= 1'b0;
          end
        end
        LEN: begin
          if (xfer) begin
            remaining <= in_data;
            if (in_data == '0) begin
              state <= DONE;
              eob   <= 1'b1;
            end else begin
              state <= HDR;
            end
          end
        end
        HDR: begin
          if (xfer) begin
            // Clip a header that claims more elements than the object has left
            if (hdr_len > remaining) begin
              cnt <= remaining;
              err <= 1'b1;
            end else begin
              cnt <= hdr_len;
            end
            state <= in_data[DATA_W-1] ? RUN_VAL : LIT;
          end
        end
        RUN_VAL: begin
          if (xfer) begin
            run_val <= in_data;
            state   <= last ? exit_state : RUN_EMIT;
          end
        end
        RUN_EMIT: begin
          if (last) state <= exit_state;
        end
        LIT: begin
          if (xfer && last) state <= exit_state;
        end
        DONE: begin
          // N=0 raised eob on entry; otherwise eob lands the cycle after the last write
          eob   <= ~eob;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rle_decompressor.sv
// Directed bench for rle_decompressor: cycle table plus run/clip/wrap/reset sequences.
module tb_rle_decompressor;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       in_valid;
  logic [7:0] in_data;

  logic       a_rdy, a_ov, a_eob, a_busy, a_err;
  logic [7:0] a_od, a_oa;
  logic       b_rdy, b_ov, b_eob, b_busy, b_err;
  logic [7:0] b_od, b_oa;

  always #5 clk = ~clk;

  rle_decompressor #(.DATA_W(8), .ADDR_W(8), .BASE_ADDR(0)) dut_a (
    .clk(clk), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(a_rdy), .out_valid(a_ov), .out_data(a_od), .out_addr(a_oa),
    .eob(a_eob), .busy(a_busy), .err(a_err)
  );

  rle_decompressor #(.DATA_W(8), .ADDR_W(8), .BASE_ADDR(8'hFE)) dut_b (
    .clk(clk), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(b_rdy), .out_valid(b_ov), .out_data(b_od), .out_addr(b_oa),
    .eob(b_eob), .busy(b_busy), .err(b_err)
  );

  typedef struct {
    logic       start;
    logic       iv;
    logic [7:0] id;
    logic       rdy;
    logic       ov;
    logic [7:0] od;
    logic [7:0] oa;
    logic       eob;
    logic       busy;
    logic       err;
  } vec_t;

  typedef logic [7:0] bq_t[$];

  vec_t        vecs[$];
  logic [15:0] qa[$];
  logic [15:0] qb[$];
  int          errors = 0;
  int          checks = 0;
  int          eob_cnt = 0;
  logic        overlap = 1'b0;

  function automatic vec_t mk(logic s, logic iv, logic [7:0] id, logic rdy, logic ov,
                              logic [7:0] od, logic [7:0] oa, logic e, logic b, logic er);
    vec_t v;
    v.start = s; v.iv = iv; v.id = id; v.rdy = rdy; v.ov = ov;
    v.od = od; v.oa = oa; v.eob = e; v.busy = b; v.err = er;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (a_ov) qa.push_back({a_oa, a_od});
    if (b_ov) qb.push_back({b_oa, b_od});
    if (a_eob) eob_cnt++;
    if (a_eob && a_ov) overlap = 1'b1;
  end

  task automatic run_stream(input bq_t s);
    int n;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < s.size(); i++) begin
      in_valid = 1'b1;
      in_data  = s[i];
      n = 0;
      while (!a_rdy && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (n >= 100) begin
        checks++;
        errors++;
        $display("FAIL in_ready_timeout: byte %0d never accepted", i);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic wait_eob(input string name);
    int n;
    n = 0;
    while (!a_eob && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL %s eob_timeout: waited %0d cycles, required eob", name, n);
    end
    @(negedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;

    // Single run N=5 (0x84,0x3C), with a stray in_valid while not ready
    vecs.push_back(mk(1,0,8'h00, 0,0,8'h00,8'h00,0,0,0));
    vecs.push_back(mk(0,1,8'h05, 1,0,8'h00,8'h00,0,1,0));
    vecs.push_back(mk(0,1,8'h84, 1,0,8'h00,8'h00,0,1,0));
    vecs.push_back(mk(0,1,8'h3C, 1,0,8'h00,8'h00,0,1,0));
    vecs.push_back(mk(0,0,8'h00, 0,1,8'h3C,8'h00,0,1,0));
    vecs.push_back(mk(0,1,8'hFF, 0,1,8'h3C,8'h01,0,1,0));
    vecs.push_back(mk(0,0,8'h00, 0,1,8'h3C,8'h02,0,1,0));
    vecs.push_back(mk(0,0,8'h00, 0,1,8'h3C,8'h03,0,1,0));
    vecs.push_back(mk(0,0,8'h00, 0,1,8'h3C,8'h04,0,1,0));
    vecs.push_back(mk(0,0,8'h00, 0,0,8'h3C,8'h04,1,1,0));
    // Literal block N=3 with gapped in_valid; start during LIT is ignored
    vecs.push_back(mk(1,0,8'h00, 0,0,8'h3C,8'h04,0,0,0));
    vecs.push_back(mk(0,1,8'h03, 1,0,8'h3C,8'h04,0,1,0));
    vecs.push_back(mk(0,0,8'h00, 1,0,8'h3C,8'h04,0,1,0));
    vecs.push_back(mk(0,1,8'h02, 1,0,8'h3C,8'h04,0,1,0));
    vecs.push_back(mk(1,0,8'h00, 1,0,8'h3C,8'h04,0,1,0));
    vecs.push_back(mk(0,1,8'h11, 1,0,8'h3C,8'h04,0,1,0));
    vecs.push_back(mk(0,0,8'h00, 1,1,8'h11,8'h00,0,1,0));
    vecs.push_back(mk(0,1,8'h22, 1,0,8'h11,8'h00,0,1,0));
    vecs.push_back(mk(0,0,8'h00, 1,1,8'h22,8'h01,0,1,0));
    vecs.push_back(mk(0,1,8'h33, 1,0,8'h22,8'h01,0,1,0));
    vecs.push_back(mk(0,0,8'h00, 0,1,8'h33,8'h02,0,1,0));
    vecs.push_back(mk(0,0,8'h00, 0,0,8'h33,8'h02,1,1,0));
    // N=0
    vecs.push_back(mk(1,0,8'h00, 0,0,8'h33,8'h02,0,0,0));
    vecs.push_back(mk(0,1,8'h00, 1,0,8'h33,8'h02,0,1,0));
    vecs.push_back(mk(0,0,8'h00, 0,0,8'h33,8'h02,1,1,0));
    vecs.push_back(mk(0,0,8'h00, 0,0,8'h33,8'h02,0,0,0));

    @(negedge clk);
    @(negedge clk);
    #1;
    check("reset_a", {a_rdy, a_ov, a_od, a_oa, a_eob, a_busy, a_err}, 32'h0);
    check("reset_b_addr", {b_ov, b_oa, b_busy}, {1'b0, 8'hFE, 1'b0});
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      start    = vecs[i].start;
      in_valid = vecs[i].iv;
      in_data  = vecs[i].id;
      #1;
      check($sformatf("vec%0d {rdy,ov,data,addr,eob,busy,err}", i),
            {a_rdy, a_ov, a_od, a_oa, a_eob, a_busy, a_err},
            {vecs[i].rdy, vecs[i].ov, vecs[i].od, vecs[i].oa, vecs[i].eob, vecs[i].busy, vecs[i].err});
    end
    start    = 1'b0;
    in_valid = 1'b0;

    // Mixed run + clipped literal
    qa.delete();
    eob_cnt = 0;
    run_stream('{8'h04, 8'h81, 8'hAA, 8'h05, 8'h01, 8'h02});
    wait_eob("mixed");
    check("mixed_count", qa.size(), 4);
    if (qa.size() == 4) begin
      check("mixed_w0", qa[0], 16'h00AA);
      check("mixed_w1", qa[1], 16'h01AA);
      check("mixed_w2", qa[2], 16'h0201);
      check("mixed_w3", qa[3], 16'h0302);
    end
    check("mixed_err", a_err, 1);
    check("mixed_eob_cnt", eob_cnt, 1);

    run_stream('{8'h00});
    wait_eob("clear_err");
    check("err_cleared", a_err, 0);
    check("idle_after_n0", a_busy, 0);

    // Address wrap on the BASE_ADDR=0xFE instance
    qa.delete();
    qb.delete();
    run_stream('{8'h03, 8'h82, 8'h07});
    wait_eob("wrap");
    check("wrap_count", qb.size(), 3);
    if (qb.size() == 3) begin
      check("wrap_w0", qb[0], 16'hFE07);
      check("wrap_w1", qb[1], 16'hFF07);
      check("wrap_w2", qb[2], 16'h0007);
    end
    check("base0_count", qa.size(), 3);
    if (qa.size() == 3) check("base0_w2", qa[2], 16'h0207);

    // Reset in the middle of a run
    eob_cnt = 0;
    run_stream('{8'h0A, 8'h89, 8'h55});
    @(negedge clk);
    check("pre_reset_emitting", a_ov, 1);
    #2;
    reset = 1'b0;
    #1;
    check("async_reset_a", {a_rdy, a_ov, a_od, a_oa, a_eob, a_busy, a_err}, 32'h0);
    check("async_reset_b_addr", {b_ov, b_oa}, {1'b0, 8'hFE});
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("no_eob_after_abort", eob_cnt, 0);
    check("idle_after_abort", a_busy, 0);

    qa.delete();
    qb.delete();
    run_stream('{8'h01, 8'h00, 8'h9E});
    wait_eob("post_reset");
    check("post_reset_count", qa.size(), 1);
    if (qa.size() == 1) check("post_reset_w0", qa[0], 16'h009E);
    if (qb.size() == 1) check("post_reset_b_w0", qb[0], 16'hFE9E);
    check("eob_out_valid_overlap", overlap, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rle_decompressor.md
Name: rle_decompressor

Overview:
- Per-object run-length decompressor. One instance per io_fsm byte lane (A, B, U, rest).
- Consumes the compressed byte stream presented on its lane while its start bit is set.
- Expands the stream into element writes for the object buffer.
- Returns a one-cycle eob pulse to io_fsm when the object is complete.

Parameters:
- DATA_W, 8, width of the compressed byte and of the output elements.
- ADDR_W, 8, width of the object-buffer write address.
- BASE_ADDR, 0, address of the first element written for each object.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- start  input  1  begin a new object; sampled only in IDLE.
- in_data  input  DATA_W  compressed byte from the io_fsm lane.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  block accepts in_data this cycle.
- out_valid  output  1  out_data/out_addr carry one element write.
- out_data  output  DATA_W  decompressed element.
- out_addr  output  ADDR_W  buffer address of the element.
- eob  output  1  one-cycle pulse: object fully written.
- busy  output  1  object in progress (state not IDLE).
- err  output  1  sticky: a header overran the declared length; cleared by the next accepted start.

Behaviour:
- Reset (reset=0, asynchronous):
  - state = IDLE.
  - in_ready, out_valid, eob, busy and err = 0.
  - out_data = 0; out_addr = BASE_ADDR; internal counters = 0.
- Transfer rule: a byte transfers on a rising edge with in_valid & in_ready. in_ready is combinational from state only. It is 1 in LEN, HDR, RUN_VAL and LIT, and 0 in every other state.
- Stream format:
  - Byte 0 = N, the total element count (0..2^DATA_W-1).
  - Then headers. A header with bit7=1 is a run: count = bits[6:0]+1, and one value byte follows. A header with bit7=0 is a literal block: count = bits[6:0]+1, and that many literal bytes follow.
- States:
  - IDLE: start=1 → LEN; clear remaining, index and err. start while busy is ignored.
  - LEN: on transfer, remaining = N. N=0 → DONE, otherwise → HDR.
  - HDR: on transfer, cnt = min(bits[6:0]+1, remaining). If bits[6:0]+1 > remaining, set err. Run → RUN_VAL, literal → LIT.
  - RUN_VAL: on transfer, latch the value → RUN_EMIT.
  - RUN_EMIT: out_valid=1 every cycle with the latched value, cnt cycles in total (no input consumed).
  - LIT: each transfer produces one element; after cnt transfers leave LIT.
  - Exit from RUN_EMIT and LIT: remaining=0 → DONE, else → HDR.
  - DONE: eob=1 for exactly one cycle → IDLE.
- Output timing:
  - out_valid/out_data/out_addr are registered.
  - Literal element: valid in the cycle after its transfer.
  - Run: first copy in the cycle after the value transfer, then back-to-back copies.
- Addressing: out_addr = BASE_ADDR + index. index increments after each out_valid and wraps modulo 2^ADDR_W with no flag.
- remaining decrements once per emitted element. Arithmetic is unsigned; remaining never underflows because of the clip.
- eob is asserted in the cycle after the last out_valid. For N=0 it is asserted in the cycle after the LEN transfer. eob and out_valid are never high together.
- busy = 1 from the cycle after start is accepted until the cycle after eob.
- in_valid=0 in any input state: hold state; out_valid=0 for those cycles.
- Reset mid-object: immediate abort to the reset values. There is no eob for the aborted object.

Test Plan:
- Single run: N=5, bytes 0x84,0x3C → out_valid for 5 consecutive cycles, data 0x3C, addr 0..4; eob one cycle later; err=0.
- Literal block: N=3, bytes 0x02,0x11,0x22,0x33 with in_valid gapped every other cycle → elements 0x11,0x22,0x33 at addr 0,1,2, each one cycle after its transfer; eob after the third element.
- Mixed and clip: N=4, bytes 0x81,0xAA,0x05,0x01,0x02 → writes AA,AA,01,02; the literal header is clipped to 2 and err=1. A second start clears err.
- N=0: byte 0x00 → no out_valid; eob the cycle after the transfer; busy low the following cycle.
- Address wrap with BASE_ADDR=0xFE, N=3 run of 0x07 → out_addr sequence FE, FF, 00.
- Reset pulse (reset=0) during RUN_EMIT → all outputs go to 0 asynchronously with no eob; a new start afterwards begins at BASE_ADDR.
